// File: rtl/ldpc_layer_sched.sv
// Layered LDPC decoder scheduler: initial LLR load, per-layer VFU read
// bursts, write-back handshake and iteration / convergence control.
module ldpc_layer_sched #(
    parameter int Z          = 64,
    parameter int LAYERS     = 4,
    parameter int MAX_ITER   = 10,
    parameter int WB_TIMEOUT = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       llr_valid,
    input  logic [3:0] llr_in,
    input  logic       cfg_we,
    input  logic [1:0] cfg_layer,
    input  logic [6:0] cfg_shift,
    input  logic       vfu_wb_done,
    input  logic       syndrome_ok,
    output logic       flag_first_store,
    output logic [7:0] org_addr,
    output logic [3:0] org_data,
    output logic       org_wr_en,
    output logic [7:0] VFU_addr,
    output logic       VFU_re_en,
    output logic [6:0] cyclic_shif,
    output logic [1:0] layer_idx,
    output logic [3:0] iter_cnt,
    output logic       busy,
    output logic       done,
    output logic       converged,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE, LOAD, READ, WB_WAIT, NEXT, DONE
    } state_t;

    localparam logic [7:0] ADDR_LAST  = 8'(Z - 1);
    localparam logic [6:0] SHIFT_MAX  = 7'(Z - 1);
    localparam logic [1:0] LAYER_LAST = 2'(LAYERS - 1);
    localparam logic [3:0] ITER_LIM   = 4'(MAX_ITER);
    localparam logic [7:0] WB_LAST    = 8'(WB_TIMEOUT - 1);

    state_t     state;
    logic [6:0] shift_tab [LAYERS];
    logic [7:0] wb_cnt;
    logic [3:0] iter_nx;
    logic [1:0] layer_nx;
    logic [6:0] cfg_clamp;

    assign iter_nx   = (iter_cnt == 4'hF) ? iter_cnt : iter_cnt + 4'd1;
    assign layer_nx  = layer_idx + 2'd1;
    assign cfg_clamp = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
    assign org_wr_en = (state == LOAD) & llr_valid;
    assign org_data  = (state == LOAD) ? llr_in : 4'd0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= IDLE;
            for (int i = 0; i < LAYERS; i++) shift_tab[i] <= '0;
            wb_cnt           <= '0;
            flag_first_store <= 1'b0;
            org_addr         <= '0;
            VFU_addr         <= '0;
            VFU_re_en        <= 1'b0;
            cyclic_shif      <= '0;
            layer_idx        <= '0;
            iter_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            converged        <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            flag_first_store <= 1'b0;
            done             <= 1'b0;
            cyclic_shif      <= shift_tab[layer_idx];
            unique case (state)
                IDLE: begin
                    if (cfg_we) shift_tab[cfg_layer] <= cfg_clamp;
                    if (start) begin
                        state            <= LOAD;
                        flag_first_store <= 1'b1;
                        busy             <= 1'b1;
                        org_addr         <= '0;
                        layer_idx        <= '0;
                        iter_cnt         <= '0;
                        converged        <= 1'b0;
                        err_timeout      <= 1'b0;
                        cyclic_shif      <= shift_tab[0];
                    end
                end
                LOAD: begin
                    if (llr_valid) begin
                        if (org_addr == ADDR_LAST) begin
                            state     <= READ;
                            VFU_re_en <= 1'b1;
                            VFU_addr  <= '0;
                        end else begin
                            org_addr <= org_addr + 8'd1;
                        end
                    end
                end
                READ: begin
                    if (VFU_addr == ADDR_LAST) begin
                        VFU_re_en <= 1'b0;
                        wb_cnt    <= '0;
                        state     <= WB_WAIT;
                    end else begin
                        VFU_addr <= VFU_addr + 8'd1;
                    end
                end
                WB_WAIT: begin
                    if (vfu_wb_done) begin
                        state <= NEXT;
                    end else if (wb_cnt == WB_LAST) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wb_cnt <= wb_cnt + 8'd1;
                    end
                end
                NEXT: begin
                    // shift is steered to the new layer so the first read beat carries it
                    if (layer_idx != LAYER_LAST) begin
                        layer_idx   <= layer_nx;
                        cyclic_shif <= shift_tab[layer_nx];
                        state       <= READ;
                        VFU_re_en   <= 1'b1;
                        VFU_addr    <= '0;
                    end else begin
                        iter_cnt <= iter_nx;
                        if (syndrome_ok) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            converged <= 1'b1;
                        end else if (iter_nx == ITER_LIM) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            layer_idx   <= '0;
                            cyclic_shif <= shift_tab[0];
                            state       <= READ;
                            VFU_re_en   <= 1'b1;
                            VFU_addr    <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// Scoreboard bench for ldpc_layer_sched: directed load, read, convergence,
// iteration limit, write-back timeout and abort scenarios.
module tb_ldpc_layer_sched;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       llr_valid = 1'b0;
    logic [3:0] llr_in = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_layer = '0;
    logic [6:0] cfg_shift = '0;
    logic       vfu_wb_done = 1'b0;
    logic       syndrome_ok = 1'b0;
    logic       flag_first_store;
    logic [7:0] org_addr;
    logic [3:0] org_data;
    logic       org_wr_en;
    logic [7:0] VFU_addr;
    logic       VFU_re_en;
    logic [6:0] cyclic_shif;
    logic [1:0] layer_idx;
    logic [3:0] iter_cnt;
    logic       busy;
    logic       done;
    logic       converged;
    logic       err_timeout;

    ldpc_layer_sched dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .llr_valid(llr_valid), .llr_in(llr_in), .cfg_we(cfg_we),
        .cfg_layer(cfg_layer), .cfg_shift(cfg_shift),
        .vfu_wb_done(vfu_wb_done), .syndrome_ok(syndrome_ok),
        .flag_first_store(flag_first_store), .org_addr(org_addr),
        .org_data(org_data), .org_wr_en(org_wr_en), .VFU_addr(VFU_addr),
        .VFU_re_en(VFU_re_en), .cyclic_shif(cyclic_shif),
        .layer_idx(layer_idx), .iter_cnt(iter_cnt), .busy(busy),
        .done(done), .converged(converged), .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;
    int ffs_cnt = 0;
    int bursts = 0;

    logic [11:0] load_q [$];
    logic [14:0] rd_q [$];
    logic [5:0]  done_q [$];
    logic [6:0]  exp_shift [4] = '{7'd5, 7'd0, 7'd63, 7'd63};

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: output with empty scoreboard queue", name);
    endtask

    // Monitor: pops expected responses whenever the DUT presents output
    initial begin
        logic re_q;
        re_q = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (flag_first_store) ffs_cnt++;
                if (VFU_re_en && !re_q) bursts++;
                re_q = VFU_re_en;
                if (org_wr_en) begin
                    if (load_q.size() == 0) unexpected("load");
                    else check("load", {org_addr, org_data}, load_q.pop_front());
                end
                if (VFU_re_en) begin
                    if (rd_q.size() == 0) unexpected("read");
                    else check("read", {VFU_addr, cyclic_shif}, rd_q.pop_front());
                end
                if (done) begin
                    if (done_q.size() == 0) unexpected("done");
                    else check("done", {converged, iter_cnt, err_timeout},
                               done_q.pop_front());
                end
            end else begin
                re_q = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_re(input logic lvl, input int budget, input string name);
        int n = 0;
        while (VFU_re_en !== lvl && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (VFU_re_en !== lvl) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: VFU_re_en=%b not reached in %0d cycles", name, lvl, budget);
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: no done pulse in %0d cycles", budget);
        end
    endtask

    task automatic cfg(input logic [1:0] l, input logic [6:0] s);
        cfg_we = 1'b1;
        cfg_layer = l;
        cfg_shift = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic push_bursts(input int n);
        for (int b = 0; b < n; b++)
            for (int a = 0; a < 64; a++)
                rd_q.push_back({8'(a), exp_shift[b % 4]});
    endtask

    task automatic load(input int gap_at);
        int g = gap_at;
        for (int i = 0; i < 64; i++)
            load_q.push_back({8'(i), 4'((i * 7 + 3) & 15)});
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b0;
        for (int i = 0; i < 64;) begin
            if (i == g) begin
                llr_valid = 1'b0;
                g = -1;
                tick();
            end else begin
                llr_valid = 1'b1;
                llr_in = 4'((i * 7 + 3) & 15);
                tick();
                i++;
            end
        end
        llr_valid = 1'b0;
        llr_in = '0;
    endtask

    task automatic run_layer(input logic s);
        wait_re(1'b1, 300, "burst_start");
        wait_re(1'b0, 100, "burst_end");
        tick();
        vfu_wb_done = 1'b1;
        syndrome_ok = s;
        tick();
        vfu_wb_done = 1'b0;
        tick();
        syndrome_ok = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        check("reset_outputs",
              {flag_first_store, org_addr, org_data, org_wr_en, VFU_addr,
               VFU_re_en, cyclic_shif, layer_idx, iter_cnt, busy, done,
               converged, err_timeout}, 64'd0);
        #20;
        sys_rst_n = 1'b1;
        tick();

        // Convergence after two iterations; last shift write coincides with start
        cfg(2'd0, 7'd5);
        cfg(2'd1, 7'd0);
        cfg(2'd2, 7'd63);
        cfg_we = 1'b1;
        cfg_layer = 2'd3;
        cfg_shift = 7'd70;
        push_bursts(8);
        done_q.push_back({1'b1, 4'd2, 1'b0});
        load(10);
        wait_re(1'b1, 10, "first_read");
        check("org_addr_hold", org_addr, 64'd63);
        check("first_store_once", ffs_cnt, 64'd1);
        for (int k = 0; k < 8; k++) run_layer(k == 7);
        wait_done(50, n);
        tick();
        tick();
        check("conv_hold", {converged, iter_cnt, busy, done}, {1'b1, 4'd2, 2'b00});

        // Iteration limit
        bursts = 0;
        push_bursts(40);
        done_q.push_back({1'b0, 4'd10, 1'b0});
        load(-1);
        for (int k = 0; k < 40; k++) run_layer(1'b0);
        wait_done(50, n);
        tick();
        check("burst_count", bursts, 64'd40);

        // Write-back timeout; a stray wb pulse during READ must be ignored
        push_bursts(1);
        done_q.push_back({1'b0, 4'd0, 1'b1});
        load(-1);
        wait_re(1'b1, 10, "timeout_read");
        repeat (10) tick();
        vfu_wb_done = 1'b1;
        tick();
        vfu_wb_done = 1'b0;
        wait_re(1'b0, 100, "timeout_read_end");
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check("timeout_cycles", n, 64'd255);
        tick();
        tick();
        check("err_hold", {err_timeout, busy}, 64'b10);

        // Abort: cfg and start while busy ignored, then reset mid-READ
        push_bursts(2);
        load(-1);
        wait_re(1'b1, 10, "abort_read");
        repeat (5) tick();
        cfg_we = 1'b1;
        cfg_layer = 2'd0;
        cfg_shift = 7'd33;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        wait_re(1'b0, 100, "abort_l0_end");
        tick();
        vfu_wb_done = 1'b1;
        tick();
        vfu_wb_done = 1'b0;
        wait_re(1'b1, 20, "abort_l1");
        repeat (10) tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("abort_outputs",
              {flag_first_store, org_addr, org_data, org_wr_en, VFU_addr,
               VFU_re_en, cyclic_shif, layer_idx, iter_cnt, busy, done,
               converged, err_timeout}, 64'd0);
        rd_q.delete();
        #10;
        sys_rst_n = 1'b1;
        repeat (20) tick();
        check("post_abort_idle", {busy, done, VFU_re_en, cyclic_shif}, 64'd0);
        check("first_store_total", ffs_cnt, 64'd4);
        check("load_q_empty", load_q.size(), 64'd0);
        check("rd_q_empty", rd_q.size(), 64'd0);
        check("done_q_empty", done_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
